// File: rtl/prg_uploader_pkg.sv
// Shared types and constants for the PRG upload (save) path.
package prg_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_PTR    = 4'd1,
    S_CHK    = 4'd2,
    S_HDR_LO = 4'd3,
    S_HDR_HI = 4'd4,
    S_RD     = 4'd5,
    S_CAP    = 4'd6,
    S_OUT    = 4'd7,
    S_DONE   = 4'd8
  } prg_state_t;

  localparam int          PRG_HDR_LEN = 2;
  localparam logic [15:0] C16_TXTTAB  = 16'h002B;

endpackage

// File: rtl/prg_uploader_if.sv
// Main-RAM read port plus the valid/ready byte stream toward the HPS upload shim.
interface prg_uploader_if;
  logic [15:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_dout;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    output ram_addr, ram_rd, out_data, out_valid, out_last,
    input  ram_dout, out_ready
  );

  modport slave (
    input  ram_addr, ram_rd, out_data, out_valid, out_last,
    output ram_dout, out_ready
  );
endinterface

// File: rtl/prg_uploader_stream_reg.sv
// One-entry output register: holds data/valid/last stable until the sink accepts.
module prg_stream_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       lin,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= 8'h00;
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      data  <= din;
      valid <= 1'b1;
      last  <= lin;
    end else if (valid && ready) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/prg_uploader.sv
// Streams the BASIC program in main RAM out as a PRG image (load address + bytes).
// Optional checksum output enabled by defining PRG_UPLOADER_CHKSUM_EN.
module prg_uploader
  import prg_pkg::*;
#(
  parameter logic [15:0] PTR_BASE = C16_TXTTAB
) (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic           start,
  prg_uploader_if.master bus,
  output logic [16:0]    length,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [7:0]     chksum
);

  prg_state_t  state;
  logic [15:0] start_ptr;
  logic [15:0] end_ptr;
  logic [15:0] cur;
  logic [2:0]  ptr_idx;
  logic        rd_vld_p1;
  logic [1:0]  rd_idx_p1;
  logic        load;
  logic [7:0]  load_data;
  logic        load_last;
  logic        xfer;
  logic        range_bad;

  assign xfer      = bus.out_valid & bus.out_ready;
  assign range_bad = (end_ptr <= start_ptr);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign err       = (state == S_CHK) && range_bad;
  assign bus.ram_rd = ((state == S_PTR) && !ptr_idx[2]) || (state == S_RD);

  always_comb begin
    bus.ram_addr = 16'h0000;
    if (state == S_PTR)
      bus.ram_addr = PTR_BASE + {14'd0, ptr_idx[1:0]};
    else if (state == S_RD)
      bus.ram_addr = cur;
  end

  // Header bytes come from the latched start pointer; program bytes from RAM.
  always_comb begin
    load      = 1'b0;
    load_data = 8'h00;
    load_last = 1'b0;
    case (state)
      S_HDR_LO: begin
        load      = 1'b1;
        load_data = start_ptr[7:0];
      end
      S_HDR_HI: begin
        if (!bus.out_valid || bus.out_ready) begin
          load      = 1'b1;
          load_data = start_ptr[15:8];
        end
      end
      S_CAP: begin
        load      = 1'b1;
        load_data = bus.ram_dout;
        load_last = (cur == end_ptr - 16'd1);
      end
      default: ;
    endcase
  end

  prg_stream_reg u_stream_reg (
    .clk   (clk_sys),
    .rst   (reset),
    .load  (load),
    .din   (load_data),
    .lin   (load_last),
    .ready (bus.out_ready),
    .data  (bus.out_data),
    .valid (bus.out_valid),
    .last  (bus.out_last)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr_idx   <= 3'd0;
      rd_vld_p1 <= 1'b0;
      rd_idx_p1 <= 2'd0;
      start_ptr <= 16'h0000;
      end_ptr   <= 16'h0000;
      cur       <= 16'h0000;
      length    <= 17'd0;
    end else begin
      // p1: pointer byte returns one cycle after its read was issued
      rd_vld_p1 <= (state == S_PTR) && !ptr_idx[2];
      rd_idx_p1 <= ptr_idx[1:0];
      if (rd_vld_p1) begin
        case (rd_idx_p1)
          2'd0: start_ptr[7:0]  <= bus.ram_dout;
          2'd1: start_ptr[15:8] <= bus.ram_dout;
          2'd2: end_ptr[7:0]    <= bus.ram_dout;
          2'd3: end_ptr[15:8]   <= bus.ram_dout;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_PTR;
            ptr_idx <= 3'd0;
          end
        end
        // Index 4 is a drain cycle letting the last pointer byte land.
        S_PTR: begin
          if (ptr_idx == 3'd4) state <= S_CHK;
          else ptr_idx <= ptr_idx + 3'd1;
        end
        S_CHK: begin
          if (range_bad) begin
            state <= S_IDLE;
          end else begin
            length <= {1'b0, end_ptr} - {1'b0, start_ptr} + 17'(PRG_HDR_LEN);
            cur    <= start_ptr;
            state  <= S_HDR_LO;
          end
        end
        S_HDR_LO: state <= S_HDR_HI;
        S_HDR_HI: if (load) state <= S_RD;
        // Only read once the output register is guaranteed free for S_CAP.
        S_RD: if (!bus.out_valid || bus.out_ready) state <= S_CAP;
        S_CAP: state <= S_OUT;
        S_OUT: begin
          if (xfer) begin
            if (bus.out_last) begin
              state <= S_DONE;
            end else begin
              cur   <= cur + 16'd1;
              state <= S_RD;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PRG_UPLOADER_CHKSUM_EN
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      chksum <= 8'h00;
    else if ((state == S_IDLE) && start)
      chksum <= 8'h00;
    else if (xfer)
      chksum <= chksum + bus.out_data;
  end
`else
  assign chksum = 8'h00;
`endif

endmodule

// File: tb/tb_prg_uploader.sv
// Directed bench for prg_uploader: RAM model, stream capture and immediate-assertion checks.
module tb_prg_uploader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [16:0] length;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  chksum;

  prg_uploader_if bus();

  prg_uploader dut (
    .clk_sys (clk),
    .reset   (reset),
    .start   (start),
    .bus     (bus),
    .length  (length),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .chksum  (chksum)
  );

`ifdef PRG_UPLOADER_CHKSUM_EN
  localparam logic [7:0] EXP_SUM = 8'h71;
`else
  localparam logic [7:0] EXP_SUM = 8'h00;
`endif

  logic [7:0] mem [0:65535];

  always_ff @(posedge clk) begin
    if (bus.ram_rd) bus.ram_dout <= mem[bus.ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] cap_data [$];
  logic       cap_last [$];
  int         n_done;
  int         n_errp;
  bit         saw_valid;
  int         first_valid;
  int         first_rd;
  logic [15:0] first_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One upload: start pulse, optional second start at cycle start2_at,
  // optional backpressure on the fourth byte for stall_len cycles.
  task automatic run_stream(input int start2_at, input int stall_len);
    int tail;
    int stalled;
    bit fin;
    cap_data.delete();
    cap_last.delete();
    n_done = 0; n_errp = 0; saw_valid = 0; first_valid = -1; first_rd = -1;
    first_addr = 16'hFFFF;
    tail = 0; stalled = 0; fin = 0;
    @(negedge clk);
    start = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      start = (c == start2_at);
      if (done) n_done++;
      if (err) n_errp++;
      if (bus.ram_rd && first_rd < 0) begin
        first_rd = c;
        first_addr = bus.ram_addr;
      end
      if (bus.out_valid) begin
        saw_valid = 1;
        if (first_valid < 0) first_valid = c;
      end
      if (bus.out_valid && cap_data.size() == 3 && stalled < stall_len) begin
        bus.out_ready = 1'b0;
        stalled++;
        check("stall_data", {24'd0, bus.out_data}, 32'h20);
        check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      end else begin
        bus.out_ready = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        cap_data.push_back(bus.out_data);
        cap_last.push_back(bus.out_last);
      end
      if (done || err) fin = 1;
      if (fin) begin
        tail++;
        if (tail > 5) break;
      end
    end
    start = 1'b0;
    check("finished", {31'd0, fin}, 32'd1);
  endtask

  task automatic check_stream(input string tag);
    logic [7:0] exp_b [5];
    exp_b = '{8'h01, 8'h10, 8'h10, 8'h20, 8'h30};
    check({tag, "_count"}, cap_data.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < cap_data.size()) begin
        check($sformatf("%s_byte%0d", tag, i), {24'd0, cap_data[i]}, {24'd0, exp_b[i]});
        check($sformatf("%s_last%0d", tag, i), {31'd0, cap_last[i]}, (i == 4) ? 32'd1 : 32'd0);
      end
    end
    check({tag, "_done"}, n_done, 32'd1);
    check({tag, "_err"}, n_errp, 32'd0);
    check({tag, "_length"}, {15'd0, length}, 32'd5);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic load_prog(input logic [7:0] e_lo);
    mem[16'h002B] = 8'h01; mem[16'h002C] = 8'h10;
    mem[16'h002D] = e_lo;  mem[16'h002E] = 8'h10;
    mem[16'h1001] = 8'h10; mem[16'h1002] = 8'h20; mem[16'h1003] = 8'h30;
  endtask

  initial begin
    bit hit;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_data", {24'd0, bus.out_data}, 32'd0);
    check("rst_last", {31'd0, bus.out_last}, 32'd0);
    check("rst_rd", {31'd0, bus.ram_rd}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_length", {15'd0, length}, 32'd0);
    check("rst_chksum", {24'd0, chksum}, 32'd0);

    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("start_during_reset_ignored", {31'd0, busy}, 32'd0);

    // Case 1 and checksum
    load_prog(8'h04);
    run_stream(-1, 0);
    check_stream("c1");
    check("c1_first_rd_cycle", first_rd, 32'd0);
    check("c1_first_rd_addr", {16'd0, first_addr}, 32'h2B);
    check("c1_hdr_lo_cycle", first_valid, 32'd7);
    check("c1_chksum", {24'd0, chksum}, {24'd0, EXP_SUM});

    // Case 2: empty range
    load_prog(8'h01);
    run_stream(-1, 0);
    check("c2_err", n_errp, 32'd1);
    check("c2_done", n_done, 32'd0);
    check("c2_no_valid", {31'd0, saw_valid}, 32'd0);
    check("c2_busy_after", {31'd0, busy}, 32'd0);

    // Case 3: backpressure on byte 20
    load_prog(8'h04);
    run_stream(-1, 10);
    check_stream("c3");
    check("c3_chksum", {24'd0, chksum}, {24'd0, EXP_SUM});

    // Case 5: second start mid-stream is ignored
    run_stream(9, 0);
    check_stream("c5");

    // Case 4: asynchronous reset while byte 20 is held
    @(negedge clk);
    start = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.out_valid && bus.out_data == 8'h20) begin
        bus.out_ready = 1'b0;
        hit = 1;
        break;
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
    check("c4_reached_20", {31'd0, hit}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("c4_valid0", {31'd0, bus.out_valid}, 32'd0);
    check("c4_data0", {24'd0, bus.out_data}, 32'd0);
    check("c4_busy0", {31'd0, busy}, 32'd0);
    check("c4_rd0", {31'd0, bus.ram_rd}, 32'd0);
    check("c4_length0", {15'd0, length}, 32'd0);
    check("c4_chksum0", {24'd0, chksum}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || err) n_done++;
    end
    check("c4_no_done", n_done, 32'd0);
    run_stream(-1, 0);
    check_stream("c4_restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
